// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared types and helpers for the switch statistics slice
package switch_pkg;

    typedef enum logic [1:0] {
        PKT      = 2'd0,
        ACC_FAN  = 2'd1,
        DROP_FAN = 2'd2,
        DLV      = 2'd3
    } stat_sel_e;

    localparam int STAT_SEL_W = 2;
    localparam int MAX_PORTS  = 16;

    // Callers zero-extend their NUM_PORTS-wide mask and truncate the result to their own fan width
    function automatic logic [4:0] popcount(input logic [MAX_PORTS-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            n = n + {4'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/stat_counter.sv
// rtl/stat_counter.sv - one saturating statistics counter with its snapshot shadow
module stat_counter #(
    parameter int CNT_W = 16,
    parameter int INC_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INC_W-1:0] i_inc,
    input  logic             i_snap,
    input  logic             i_clr_on_snap,
    output logic [CNT_W-1:0] o_shadow
);

    localparam int SUM_W = CNT_W + INC_W;

    logic [CNT_W-1:0] r_live;
    logic [CNT_W-1:0] r_shadow;
    logic [SUM_W-1:0] w_sum;
    logic [CNT_W-1:0] w_next;

    assign w_sum  = SUM_W'(r_live) + SUM_W'(i_inc);
    assign w_next = (|w_sum[SUM_W-1:CNT_W]) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

    // The shadow takes the post-increment value so events on the snap edge are never lost
    always_ff @(posedge clk) begin
        if (rst) begin
            r_live   <= '0;
            r_shadow <= '0;
        end else if (i_snap) begin
            r_shadow <= w_next;
            r_live   <= i_clr_on_snap ? '0 : w_next;
        end else begin
            r_live   <= w_next;
        end
    end

    assign o_shadow = r_shadow;

endmodule

// File: rtl/switch_stats_unit.sv
// rtl/switch_stats_unit.sv - per-port traffic counters, snapshot readout and in-flight tracking
module switch_stats_unit
    import switch_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int CNT_W       = 16,
    parameter int CLR_ON_SNAP = 0,
    parameter int PORT_W      = $clog2(NUM_PORTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           valid_in,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] target_in,
    input  logic [NUM_PORTS-1:0]           fifo_full,
    input  logic [NUM_PORTS-1:0]           valid_out,
    input  logic                           snap_req,
    output logic                           snap_ack,
    input  logic                           rd_en,
    input  logic [PORT_W+1:0]              rd_addr,
    output logic                           rd_valid,
    output logic [CNT_W-1:0]               rd_data,
    output logic [CNT_W-1:0]               inflight,
    output logic                           err_underflow
);

    localparam int INC_W = $clog2(NUM_PORTS) + 1;
    localparam int IW    = CNT_W + $clog2(NUM_PORTS * NUM_PORTS) + 1;

    logic [INC_W-1:0] w_fan    [NUM_PORTS];
    logic [INC_W-1:0] w_inc    [NUM_PORTS][4];
    logic [CNT_W-1:0] w_shadow [NUM_PORTS][4];
    logic [IW-1:0]    w_if_next;
    logic [CNT_W-1:0] w_rd_mux;

    logic [CNT_W-1:0] r_inflight;
    logic             r_err_underflow;
    logic             r_snap_ack;
    logic             r_rd_valid;
    logic [CNT_W-1:0] r_rd_data;

    always_comb begin
        w_if_next = IW'(r_inflight);
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_fan[p] = INC_W'(popcount(MAX_PORTS'(target_in[p*NUM_PORTS +: NUM_PORTS])));
            w_inc[p][PKT]      = INC_W'(valid_in[p]);
            w_inc[p][ACC_FAN]  = (valid_in[p] && !fifo_full[p]) ? w_fan[p] : '0;
            w_inc[p][DROP_FAN] = (valid_in[p] &&  fifo_full[p]) ? w_fan[p] : '0;
            w_inc[p][DLV]      = INC_W'(valid_out[p]);
            w_if_next = w_if_next + IW'(w_inc[p][ACC_FAN]) - IW'(valid_out[p]);
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        for (genvar s = 0; s < 4; s++) begin : g_stat
            stat_counter #(.CNT_W(CNT_W), .INC_W(INC_W)) u_cnt (
                .clk           (clk),
                .rst           (rst),
                .i_inc         (w_inc[p][s]),
                .i_snap        (snap_req),
                .i_clr_on_snap (CLR_ON_SNAP != 0),
                .o_shadow      (w_shadow[p][s])
            );
        end
    end

    // Unpopulated port indices fall through to zero
    always_comb begin
        w_rd_mux = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rd_addr[PORT_W+1:STAT_SEL_W] == PORT_W'(p)) begin
                w_rd_mux = w_shadow[p][rd_addr[STAT_SEL_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight      <= '0;
            r_err_underflow <= 1'b0;
            r_snap_ack      <= 1'b0;
            r_rd_valid      <= 1'b0;
            r_rd_data       <= '0;
        end else begin
            r_snap_ack <= snap_req;
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_mux;
            end
            if (w_if_next[IW-1]) begin
                r_inflight      <= '0;
                r_err_underflow <= 1'b1;
            end else if (|w_if_next[IW-2:CNT_W]) begin
                r_inflight <= {CNT_W{1'b1}};
            end else begin
                r_inflight <= w_if_next[CNT_W-1:0];
            end
        end
    end

    assign snap_ack      = r_snap_ack;
    assign rd_valid      = r_rd_valid;
    assign rd_data       = r_rd_data;
    assign inflight      = r_inflight;
    assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_switch_stats_unit.sv
// tb/tb_switch_stats_unit.sv - directed self-checking bench for switch_stats_unit
module tb_switch_stats_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int n_cmp = 0;
    int n_bad = 0;

    // A: 4 ports, 16-bit, free-running
    logic [3:0]  a_valid_in, a_fifo_full, a_valid_out, a_rd_addr;
    logic [15:0] a_target, a_rd_data, a_inflight;
    logic        a_snap, a_snap_ack, a_rd_en, a_rd_valid, a_err;
    // B: 4 ports, 4-bit, clear on snapshot
    logic [3:0]  b_valid_in, b_fifo_full, b_valid_out, b_rd_addr, b_rd_data, b_inflight;
    logic [15:0] b_target;
    logic        b_snap, b_snap_ack, b_rd_en, b_rd_valid, b_err;
    // C: 3 ports, so port index 3 is unpopulated
    logic [2:0]  c_valid_in, c_fifo_full, c_valid_out;
    logic [8:0]  c_target;
    logic [3:0]  c_rd_addr;
    logic [15:0] c_rd_data, c_inflight;
    logic        c_snap, c_snap_ack, c_rd_en, c_rd_valid, c_err;

    switch_stats_unit #(.NUM_PORTS(4), .CNT_W(16), .CLR_ON_SNAP(0)) u_dut_a (
        .clk(clk), .rst(rst), .valid_in(a_valid_in), .target_in(a_target),
        .fifo_full(a_fifo_full), .valid_out(a_valid_out), .snap_req(a_snap),
        .snap_ack(a_snap_ack), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
        .rd_valid(a_rd_valid), .rd_data(a_rd_data), .inflight(a_inflight),
        .err_underflow(a_err)
    );

    switch_stats_unit #(.NUM_PORTS(4), .CNT_W(4), .CLR_ON_SNAP(1)) u_dut_b (
        .clk(clk), .rst(rst), .valid_in(b_valid_in), .target_in(b_target),
        .fifo_full(b_fifo_full), .valid_out(b_valid_out), .snap_req(b_snap),
        .snap_ack(b_snap_ack), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
        .rd_valid(b_rd_valid), .rd_data(b_rd_data), .inflight(b_inflight),
        .err_underflow(b_err)
    );

    switch_stats_unit #(.NUM_PORTS(3), .CNT_W(16), .CLR_ON_SNAP(0)) u_dut_c (
        .clk(clk), .rst(rst), .valid_in(c_valid_in), .target_in(c_target),
        .fifo_full(c_fifo_full), .valid_out(c_valid_out), .snap_req(c_snap),
        .snap_ack(c_snap_ack), .rd_en(c_rd_en), .rd_addr(c_rd_addr),
        .rd_valid(c_rd_valid), .rd_data(c_rd_data), .inflight(c_inflight),
        .err_underflow(c_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rd_a(input logic [3:0] addr, input logic [15:0] exp, input string tag);
        a_rd_en = 1'b1; a_rd_addr = addr;
        tick();
        chk({tag, " rd_valid"}, 32'(a_rd_valid), 32'd1);
        chk(tag, 32'(a_rd_data), 32'(exp));
        a_rd_en = 1'b0;
    endtask

    task automatic rd_b(input logic [3:0] addr, input logic [3:0] exp, input string tag);
        b_rd_en = 1'b1; b_rd_addr = addr;
        tick();
        chk({tag, " rd_valid"}, 32'(b_rd_valid), 32'd1);
        chk(tag, 32'(b_rd_data), 32'(exp));
        b_rd_en = 1'b0;
    endtask

    task automatic rd_c(input logic [3:0] addr, input logic [15:0] exp, input string tag);
        c_rd_en = 1'b1; c_rd_addr = addr;
        tick();
        chk({tag, " rd_valid"}, 32'(c_rd_valid), 32'd1);
        chk(tag, 32'(c_rd_data), 32'(exp));
        c_rd_en = 1'b0;
    endtask

    task automatic snap_a();
        a_snap = 1'b1;
        tick();
        chk("a snap_ack high", 32'(a_snap_ack), 32'd1);
        a_snap = 1'b0;
        tick();
        chk("a snap_ack low", 32'(a_snap_ack), 32'd0);
    endtask

    task automatic snap_b();
        b_snap = 1'b1;
        tick();
        chk("b snap_ack high", 32'(b_snap_ack), 32'd1);
        b_snap = 1'b0;
        tick();
        chk("b snap_ack low", 32'(b_snap_ack), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        a_valid_in = '0; a_fifo_full = '0; a_valid_out = '0; a_target = '0;
        a_snap = 1'b0; a_rd_en = 1'b0; a_rd_addr = '0;
        b_valid_in = '0; b_fifo_full = '0; b_valid_out = '0; b_target = '0;
        b_snap = 1'b0; b_rd_en = 1'b0; b_rd_addr = '0;
        c_valid_in = '0; c_fifo_full = '0; c_valid_out = '0; c_target = '0;
        c_snap = 1'b0; c_rd_en = 1'b0; c_rd_addr = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        chk("reset inflight", 32'(a_inflight), 32'd0);
        chk("reset err", 32'(a_err), 32'd0);
        chk("reset snap_ack", 32'(a_snap_ack), 32'd0);
        chk("reset rd_valid", 32'(a_rd_valid), 32'd0);
        for (int k = 0; k < 16; k++) rd_a(4'(k), 16'd0, "reset read");
        tick();
        chk("rd_valid idle", 32'(a_rd_valid), 32'd0);

        // Port 0: three accepted packets of fan 3
        a_valid_in = 4'b0001; a_target = 16'h000E;
        tick(); tick(); tick();
        a_valid_in = '0; a_target = '0;
        chk("inflight after accepts", 32'(a_inflight), 32'd9);
        snap_a();
        rd_a(4'h0, 16'd3, "p0 pkt");
        rd_a(4'h1, 16'd9, "p0 acc");
        rd_a(4'h2, 16'd0, "p0 drop");
        rd_a(4'h3, 16'd0, "p0 dlv");

        // Port 2: two rejected packets of fan 3
        a_valid_in = 4'b0100; a_fifo_full = 4'b0100; a_target = 16'h0700;
        tick(); tick();
        a_valid_in = '0; a_fifo_full = '0; a_target = '0;
        chk("inflight after drops", 32'(a_inflight), 32'd9);
        snap_a();
        rd_a(4'h8, 16'd2, "p2 pkt");
        rd_a(4'h9, 16'd0, "p2 acc");
        rd_a(4'hA, 16'd6, "p2 drop");
        rd_a(4'h0, 16'd3, "p0 pkt free-running");

        // Drain to 3, then net 3+1-4 = 0 without error, then underflow
        a_valid_out = 4'b1111; tick();
        a_valid_out = 4'b0011; tick();
        chk("inflight drained", 32'(a_inflight), 32'd3);
        a_valid_in = 4'b0010; a_target = 16'h0080; a_valid_out = 4'b1111;
        tick();
        chk("inflight net zero", 32'(a_inflight), 32'd0);
        chk("err after net zero", 32'(a_err), 32'd0);
        a_valid_in = '0; a_target = '0; a_valid_out = 4'b0001;
        tick();
        chk("inflight clamp low", 32'(a_inflight), 32'd0);
        chk("err underflow set", 32'(a_err), 32'd1);
        a_valid_out = '0;
        tick(); tick();
        chk("err sticky", 32'(a_err), 32'd1);
        snap_a();
        rd_a(4'h3, 16'd4, "p0 dlv");
        rd_a(4'h7, 16'd3, "p1 dlv");
        rd_a(4'h5, 16'd1, "p1 acc");
        rd_a(4'hF, 16'd2, "p3 dlv");

        // Read alongside a snapshot sees the old shadow; the new one includes that cycle
        a_valid_in = 4'b0001; a_target = 16'h0001; a_snap = 1'b1;
        a_rd_en = 1'b1; a_rd_addr = 4'h0;
        tick();
        a_valid_in = '0; a_target = '0; a_snap = 1'b0; a_rd_en = 1'b0;
        chk("read during snap", 32'(a_rd_data), 32'd3);
        chk("snap_ack with read", 32'(a_snap_ack), 32'd1);
        rd_a(4'h0, 16'd4, "p0 pkt after snap");
        chk("inflight after late accept", 32'(a_inflight), 32'd1);

        // B: clear-on-snapshot, fan-0 packet counts only in pkt_cnt
        b_valid_in = 4'b1000; b_target = 16'h0000; b_snap = 1'b1;
        tick();
        chk("b snap_ack", 32'(b_snap_ack), 32'd1);
        b_snap = 1'b0;
        tick();
        chk("b snap_ack once", 32'(b_snap_ack), 32'd0);
        b_valid_in = '0;
        rd_b(4'hC, 4'd1, "b p3 pkt snap1");
        snap_b();
        rd_b(4'hC, 4'd1, "b p3 pkt snap2");
        rd_b(4'hD, 4'd0, "b p3 acc fan0");
        chk("b inflight fan0", 32'(b_inflight), 32'd0);

        // B: saturation at 15
        b_valid_in = 4'b0001; b_target = 16'h0001;
        for (int k = 0; k < 20; k++) tick();
        b_valid_in = '0; b_target = '0;
        chk("b inflight sat", 32'(b_inflight), 32'd15);
        snap_b();
        rd_b(4'h0, 4'd15, "b p0 pkt sat");
        rd_b(4'h1, 4'd15, "b p0 acc sat");
        rd_b(4'h2, 4'd0, "b p0 drop");
        snap_b();
        rd_b(4'h0, 4'd0, "b p0 pkt cleared");
        chk("b err", 32'(b_err), 32'd0);

        // C: unpopulated port index reads zero
        c_valid_in = 3'b111; c_target = 9'h1FF; c_snap = 1'b1;
        tick();
        c_valid_in = '0; c_target = '0; c_snap = 1'b0;
        chk("c inflight", 32'(c_inflight), 32'd9);
        rd_c(4'hC, 16'd0, "c port3 out of range");
        rd_c(4'h8, 16'd1, "c p2 pkt");
        rd_c(4'h9, 16'd3, "c p2 acc");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
